sd_cmd_arbiter: RTL and testbench
=================================

# sd_cmd_arbiter

Schedules the SD host CMD master between two command requesters: port 0 (host register interface) and port 1 (data-transfer engine, e.g. CMD12/CMD13 during block transfers). Grants one requester at a time, round-robin, and latches its command. Drives the CMD master's new_cmd/arg/index/timeout inputs and waits for completion or error. Returns the response and a status code to the granted requester only.

## Interface
Parameters:
- START_WAIT, 8: cycles allowed between new_cmd assertion and cmd_busy rising before the command is abandoned (1..255).

Ports:
- CLK_host  in  1  host clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has a command pending
- req0_index / req1_index  in  6  command index
- req0_arg / req1_arg  in  32  command argument
- req0_timeout / req1_timeout  in  16  timeout value forwarded to CMD master
- req0_ack / req1_ack  out  1  one-cycle pulse: command latched, requester may drop valid
- req0_done / req1_done  out  1  one-cycle pulse: command finished, rsp_* valid
- rsp_status  out  2  00 ok, 01 timeout, 10 index error, 11 no-start
- rsp_arg  out  32  latched response_arg
- rsp_index  out  6  latched response_index
- arb_busy  out  1  high whenever state is not IDLE
- new_cmd  out  1  to CMD master
- cmd_index  out  6  to CMD master
- cmd_arg  out  32  to CMD master
- timeout_value  out  16  to CMD master
- cmd_busy  in  1  from CMD master
- cmd_complete  in  1  from CMD master
- cmd_index_error  in  1  from CMD master
- timeout_error  in  1  from CMD master
- response_arg  in  32  from CMD master
- response_index  in  6  from CMD master

## Operation
- States: IDLE, ISSUE, WAIT_DONE, REPORT.
- IDLE: if any reqN_valid, grant per round-robin; latch index/arg/timeout of winner; pulse reqN_ack; record grant id; -> ISSUE. Else stay.
- Round-robin: pointer `last` (reset 1, so requester 0 wins first). Both valid: grant the one not equal to `last`. One valid: grant it. `last` updated on each grant.
- ISSUE: new_cmd=1, cmd_* driven from latches. Start counter counts cycles in ISSUE. cmd_busy=1 -> WAIT_DONE (new_cmd drops same edge). Counter reaches START_WAIT without cmd_busy -> status 11, -> REPORT.
- WAIT_DONE: new_cmd=0. Priority when sampled: timeout_error (01) > cmd_index_error (10) > cmd_complete (00). Any of these -> latch response_arg/response_index into rsp_*, set status, -> REPORT. cmd_busy falling alone does not end the command.
- REPORT: pulse done of the granted requester only; rsp_* stable from this cycle until the next REPORT. -> IDLE.
- reqN_valid changes outside IDLE are ignored; the pending requester is evaluated on the next IDLE cycle.
- cmd_index/cmd_arg/timeout_value hold last latched values outside ISSUE.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE; all outputs 0; rsp_* 0; last=1; counter 0.
- valid high in IDLE at edge k: ack pulse and ISSUE entry at edge k; new_cmd high from k to the edge after cmd_busy is first sampled high.
- Minimum command: IDLE, ISSUE (1), WAIT_DONE (>=1), REPORT (1): done no earlier than 3 cycles after ack.
- No-start: done exactly START_WAIT+1 cycles after ack.
- Back-to-back: with valid still high, the next ack is issued 1 cycle after REPORT (IDLE occupies one cycle).
- Reset mid-command: all state and outputs cleared immediately; no done pulse; the interrupted command is not retried.

## Test plan
- Single req0 (index 6'h11, arg 32'hAAAA_AAAA, timeout 15); master busy 1 cycle later, cmd_complete with response_arg 32'h7654_3210, index 6'h11 -> req0_ack, new_cmd for 2 cycles, req0_done with status 00, rsp_arg 32'h7654_3210, req1_done never.
- Both valid continuously for 4 commands -> grant order 0,1,0,1; each ack only after the previous done.
- Master never raises cmd_busy, START_WAIT=8 -> new_cmd high 8 cycles, done 9 cycles after ack, status 11.
- timeout_error and cmd_index_error sampled together -> status 01; cmd_index_error with cmd_complete -> status 10.
- reset driven low during WAIT_DONE -> new_cmd, arb_busy, all acks/dones 0 immediately; after release req0 is granted first.
- req1_valid pulsed for one cycle while arbiter is in WAIT_DONE -> ignored, no req1_ack.

Source files
------------

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter between two SD command requesters. It drives the CMD master and
// returns the response and status to the granted requester only.
module sd_cmd_arbiter #(
  parameter int START_WAIT = 8
) (
  input  logic        CLK_host,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [5:0]  req0_index,
  input  logic [31:0] req0_arg,
  input  logic [15:0] req0_timeout,
  input  logic        req1_valid,
  input  logic [5:0]  req1_index,
  input  logic [31:0] req1_arg,
  input  logic [15:0] req1_timeout,
  output logic        req0_ack,
  output logic        req1_ack,
  output logic        req0_done,
  output logic        req1_done,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_arg,
  output logic [5:0]  rsp_index,
  output logic        arb_busy,
  output logic        new_cmd,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [15:0] timeout_value,
  input  logic        cmd_busy,
  input  logic        cmd_complete,
  input  logic        cmd_index_error,
  input  logic        timeout_error,
  input  logic [31:0] response_arg,
  input  logic [5:0]  response_index
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REPORT} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        gnt_id;
  logic        gnt_nxt;
  logic        any_req;
  logic        start_expired;
  logic        cmd_end;
  logic [1:0]  end_status;
  logic [7:0]  start_cnt;

  assign any_req       = req0_valid | req1_valid;
  assign start_expired = (start_cnt == 8'(START_WAIT - 1));
  assign cmd_end       = timeout_error | cmd_index_error | cmd_complete;
  assign new_cmd       = (state == ISSUE);
  assign arb_busy      = (state != IDLE);

  // With both requesting, the one not served last wins; otherwise whoever asks.
  always_comb begin
    gnt_nxt = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_nxt = ~last;
    end
  end

  always_comb begin
    end_status = 2'b00;
    if (timeout_error) begin
      end_status = 2'b01;
    end else if (cmd_index_error) begin
      end_status = 2'b10;
    end
  end

  always_ff @(posedge CLK_host or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        if (cmd_busy) begin
          state_nxt = WAIT_DONE;
        end else if (start_expired) begin
          state_nxt = REPORT;
        end
      end
      WAIT_DONE: if (cmd_end) state_nxt = REPORT;
      REPORT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_host or negedge reset) begin
    if (!reset) begin
      last          <= 1'b1;
      gnt_id        <= 1'b0;
      start_cnt     <= 8'd0;
      req0_ack      <= 1'b0;
      req1_ack      <= 1'b0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      rsp_status    <= 2'b00;
      rsp_arg       <= 32'd0;
      rsp_index     <= 6'd0;
      cmd_index     <= 6'd0;
      cmd_arg       <= 32'd0;
      timeout_value <= 16'd0;
    end else begin
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id        <= gnt_nxt;
            last          <= gnt_nxt;
            req0_ack      <= ~gnt_nxt;
            req1_ack      <= gnt_nxt;
            cmd_index     <= gnt_nxt ? req1_index   : req0_index;
            cmd_arg       <= gnt_nxt ? req1_arg     : req0_arg;
            timeout_value <= gnt_nxt ? req1_timeout : req0_timeout;
          end
        end
        ISSUE: begin
          if (cmd_busy) begin
            start_cnt <= 8'd0;
          end else if (start_expired) begin
            start_cnt  <= 8'd0;
            rsp_status <= 2'b11;
          end else begin
            start_cnt <= start_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          // A falling cmd_busy on its own is not a completion; only the flags end it.
          if (cmd_end) begin
            rsp_status <= end_status;
            rsp_arg    <= response_arg;
            rsp_index  <= response_index;
          end
        end
        REPORT: begin
          req0_done <= ~gnt_id;
          req1_done <= gnt_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: grant order, latency, status priority and reset abort.
module tb_sd_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_index, req1_index;
  logic [31:0] req0_arg, req1_arg;
  logic [15:0] req0_timeout, req1_timeout;
  logic        req0_ack, req1_ack, req0_done, req1_done;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_arg;
  logic [5:0]  rsp_index;
  logic        arb_busy, new_cmd;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [15:0] timeout_value;
  logic        cmd_busy, cmd_complete, cmd_index_error, timeout_error;
  logic [31:0] response_arg;
  logic [5:0]  response_index;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_ack0 = 0, cnt_ack1 = 0, cnt_done0 = 0, cnt_done1 = 0;

  sd_cmd_arbiter #(.START_WAIT(8)) dut (
    .CLK_host(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_index(req0_index), .req0_arg(req0_arg), .req0_timeout(req0_timeout),
    .req1_valid(req1_valid), .req1_index(req1_index), .req1_arg(req1_arg), .req1_timeout(req1_timeout),
    .req0_ack(req0_ack), .req1_ack(req1_ack), .req0_done(req0_done), .req1_done(req1_done),
    .rsp_status(rsp_status), .rsp_arg(rsp_arg), .rsp_index(rsp_index),
    .arb_busy(arb_busy), .new_cmd(new_cmd), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .timeout_value(timeout_value), .cmd_busy(cmd_busy), .cmd_complete(cmd_complete),
    .cmd_index_error(cmd_index_error), .timeout_error(timeout_error),
    .response_arg(response_arg), .response_index(response_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req0_ack)  cnt_ack0++;
    if (req1_ack)  cnt_ack1++;
    if (req0_done) cnt_done0++;
    if (req1_done) cnt_done1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues busy then a completion flag set; leaves the arbiter just after the done edge.
  task automatic finish_cmd(input logic to_e, input logic idx_e, input logic cpl,
                            input logic [31:0] rarg, input logic [5:0] ridx);
    cmd_busy = 1'b1;
    tick();
    timeout_error = to_e; cmd_index_error = idx_e; cmd_complete = cpl;
    response_arg = rarg; response_index = ridx;
    tick();
    timeout_error = 1'b0; cmd_index_error = 1'b0; cmd_complete = 1'b0; cmd_busy = 1'b0;
    tick();
  endtask

  initial begin
    int cyc, ncmd, base_done, base_ack1, base_done1;
    logic got_id;

    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_index = 6'h11; req0_arg = 32'hAAAA_AAAA; req0_timeout = 16'd15;
    req1_index = 6'h0C; req1_arg = 32'h1234_5678; req1_timeout = 16'd99;
    cmd_busy = 1'b0; cmd_complete = 1'b0; cmd_index_error = 1'b0; timeout_error = 1'b0;
    response_arg = 32'd0; response_index = 6'd0;
    tick(); tick();
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_new_cmd", 32'(new_cmd), 32'd0);
    chk("rst_rsp", {rsp_status, rsp_index, 24'(rsp_arg)}, 32'd0);
    chk("rst_cmd_arg", cmd_arg, 32'd0);
    reset = 1'b1;
    tick();

    // Single req0 command with normal completion
    req0_valid = 1'b1;
    tick();
    chk("t1_ack0", {31'd0, req0_ack}, 32'd1);
    chk("t1_new_cmd_a", 32'(new_cmd), 32'd1);
    chk("t1_cmd_index", 32'(cmd_index), 32'h11);
    chk("t1_cmd_arg", cmd_arg, 32'hAAAA_AAAA);
    chk("t1_timeout", 32'(timeout_value), 32'd15);
    req0_valid = 1'b0;
    tick();
    chk("t1_ack0_pulse", 32'(req0_ack), 32'd0);
    chk("t1_new_cmd_b", 32'(new_cmd), 32'd1);
    cmd_busy = 1'b1;
    tick();
    chk("t1_new_cmd_drop", 32'(new_cmd), 32'd0);
    cmd_complete = 1'b1; response_arg = 32'h7654_3210; response_index = 6'h11;
    tick();
    chk("t1_rsp_arg", rsp_arg, 32'h7654_3210);
    chk("t1_done_early", 32'(req0_done), 32'd0);
    cmd_complete = 1'b0; cmd_busy = 1'b0;
    tick();
    chk("t1_done0", 32'(req0_done), 32'd1);
    chk("t1_status", 32'(rsp_status), 32'd0);
    chk("t1_rsp_index", 32'(rsp_index), 32'h11);
    chk("t1_arb_idle", 32'(arb_busy), 32'd0);
    tick();
    chk("t1_done1_never", 32'(cnt_done1), 32'd0);

    // Round robin with both requesters held high
    reset = 1'b0; tick(); reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    base_done = cnt_done0 + cnt_done1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      got_id = 1'b0;
      while (cyc < 20) begin
        tick();
        cyc++;
        if (req0_ack || req1_ack) begin
          got_id = req1_ack;
          break;
        end
      end
      chk($sformatf("rr_ack_wait_%0d", i), 32'(cyc), 32'd1);
      chk($sformatf("rr_grant_%0d", i), 32'(got_id), 32'(i % 2));
      chk($sformatf("rr_prev_done_%0d", i), 32'(cnt_done0 + cnt_done1 - base_done), 32'(i));
      finish_cmd(1'b0, 1'b0, 1'b1, 32'(i + 100), 6'(i));
      if (i == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      chk($sformatf("rr_done_%0d", i), {30'd0, req1_done, req0_done}, (i % 2) ? 32'd2 : 32'd1);
      chk($sformatf("rr_rsp_%0d", i), rsp_arg, 32'(i + 100));
    end
    tick(); tick();
    chk("rr_no_extra_ack", 32'(arb_busy), 32'd0);

    // No-start: master never raises cmd_busy
    req0_valid = 1'b1;
    tick();
    chk("ns_ack0", 32'(req0_ack), 32'd1);
    req0_valid = 1'b0;
    ncmd = 32'(new_cmd);
    cyc = 0;
    while (cyc < 30) begin
      tick();
      cyc++;
      ncmd += 32'(new_cmd);
      if (req0_done) break;
    end
    chk("ns_done_latency", 32'(cyc), 32'd9);
    chk("ns_new_cmd_cycles", 32'(ncmd), 32'd8);
    chk("ns_status", 32'(rsp_status), 32'd3);

    // timeout_error beats cmd_index_error
    req1_valid = 1'b1;
    tick();
    chk("pr1_ack1", 32'(req1_ack), 32'd1);
    req1_valid = 1'b0;
    finish_cmd(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 6'h03);
    chk("pr1_done1", {30'd0, req1_done, req0_done}, 32'd2);
    chk("pr1_status", 32'(rsp_status), 32'd1);
    chk("pr1_rsp_arg", rsp_arg, 32'hDEAD_BEEF);
    chk("pr1_rsp_index", 32'(rsp_index), 32'h03);

    // cmd_index_error beats cmd_complete; busy falling alone and a req1 blip are ignored
    base_ack1 = cnt_ack1;
    req0_valid = 1'b1;
    tick();
    chk("pr2_ack0", 32'(req0_ack), 32'd1);
    req0_valid = 1'b0;
    cmd_busy = 1'b1;
    tick();
    cmd_busy = 1'b0;
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("pr2_busy_fall_hold", 32'(arb_busy), 32'd1);
    chk("pr2_no_early_done", 32'(req0_done), 32'd0);
    finish_cmd(1'b0, 1'b1, 1'b1, 32'h0BAD_F00D, 6'h2A);
    chk("pr2_done0", {30'd0, req1_done, req0_done}, 32'd1);
    chk("pr2_status", 32'(rsp_status), 32'd2);
    tick(); tick();
    chk("blip_no_ack1", 32'(cnt_ack1 - base_ack1), 32'd0);
    chk("blip_idle", 32'(arb_busy), 32'd0);

    // Reset during WAIT_DONE aborts without a done pulse
    base_done1 = cnt_done1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    chk("rm_ack1", 32'(req1_ack), 32'd1);
    cmd_busy = 1'b1;
    tick();
    chk("rm_in_wait", {30'd0, arb_busy, new_cmd}, 32'd2);
    reset = 1'b0;
    #1;
    chk("rm_async_clear", {28'd0, arb_busy, new_cmd, req0_ack, req1_ack}, 32'd0);
    chk("rm_cmd_clear", 32'(cmd_index), 32'd0);
    cmd_busy = 1'b0;
    tick(); tick();
    chk("rm_no_done", {30'd0, req1_done, req0_done}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rm_regrant0", {30'd0, req1_ack, req0_ack}, 32'd1);
    chk("rm_no_done1", 32'(cnt_done1 - base_done1), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
